// File: rtl/mac_accum_stage.sv
// Sums vec_len unsigned products per vector into an ACC_W accumulator and presents a dot-product result with overflow flagging.
// Latency: result valid 1 cycle after the last product of a vector; back-to-back vectors need no dead cycle.
// Backpressure: input never stalls; a completion while the held result is unaccepted is dropped and sets sticky overrun.
module mac_accum_stage #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic              sat_en,
    output logic [ACC_W-1:0]  res_out,
    output logic              res_sat,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W:0]     sum;
    logic               carry;
    logic [ACC_W-1:0]   acc_add;
    logic [LEN_W-1:0]   len_eff;
    logic [LEN_W-1:0]   cnt_inc;
    logic               complete;
    logic [ACC_W-1:0]   cand;
    logic               cand_sat;

    assign prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod_in};
    assign sum      = {1'b0, acc_q} + {1'b0, prod_ext};
    assign carry    = sum[ACC_W];
    // Saturated accumulator plus any nonzero product carries again, so it stays pinned at all-ones.
    assign acc_add  = (carry && sat_en) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    assign len_eff  = (vec_len == '0) ? LEN_W'(1) : vec_len;
    assign cnt_inc  = cnt_q + LEN_W'(1);
    assign busy     = (state_q == ACCUM);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        complete = 1'b0;
        cand     = acc_q;
        cand_sat = ovf_q;
        if (prod_valid) begin
            case (state_q)
                IDLE: begin
                    len_d = len_eff;
                    acc_d = prod_ext;
                    cnt_d = LEN_W'(1);
                    ovf_d = 1'b0;
                    if (len_eff == LEN_W'(1)) begin
                        complete = 1'b1;
                        cand     = prod_ext;
                        cand_sat = 1'b0;
                    end else begin
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    acc_d = acc_add;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | carry;
                    if (cnt_inc == len_q) begin
                        complete = 1'b1;
                        cand     = acc_add;
                        cand_sat = ovf_q | carry;
                        state_d  = IDLE;
                    end
                end
                default: ;
            endcase
            if (complete) begin
                acc_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            res_out   <= '0;
            res_sat   <= 1'b0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (clr) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            res_out   <= '0;
            res_sat   <= 1'b0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            if (complete) begin
                // Output slot is free if empty or being drained this same edge.
                if (!res_valid || res_ready) begin
                    res_out   <= cand;
                    res_sat   <= cand_sat;
                    res_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_accum_stage.sv
// Directed, table-driven bench for mac_accum_stage; a second narrow-accumulator instance exercises overflow paths.
module tb_mac_accum_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [15:0] prod_in;
    logic        prod_valid;
    logic [7:0]  vec_len;
    logic        sat_en;
    logic        res_ready;
    logic [23:0] res_out;
    logic        res_sat, res_valid, overrun, busy;

    logic [15:0] s_prod;
    logic        s_valid;
    logic [7:0]  s_len;
    logic        s_sat_en;
    logic [16:0] s_res;
    logic        s_res_sat, s_res_valid, s_overrun, s_busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mac_accum_stage u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .prod_in(prod_in), .prod_valid(prod_valid),
        .vec_len(vec_len), .sat_en(sat_en), .res_out(res_out), .res_sat(res_sat),
        .res_valid(res_valid), .res_ready(res_ready), .overrun(overrun), .busy(busy)
    );

    mac_accum_stage #(.PROD_W(16), .ACC_W(17), .LEN_W(8)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .prod_in(s_prod), .prod_valid(s_valid),
        .vec_len(s_len), .sat_en(s_sat_en), .res_out(s_res), .res_sat(s_res_sat),
        .res_valid(s_res_valid), .res_ready(1'b1), .overrun(s_overrun), .busy(s_busy)
    );

    typedef struct {
        logic        pv;
        logic [15:0] prod;
        logic [7:0]  len;
        logic        rdy;
        logic        clr;
        logic        e_vld;
        logic [23:0] e_res;
        logic        e_sat;
        logic        e_ovr;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic pv, input int prod, input int len, input logic rdy, input logic c,
                       input logic ev, input int eres, input logic es, input logic eo, input logic eb);
        vec_t v;
        v.pv = pv; v.prod = prod[15:0]; v.len = len[7:0]; v.rdy = rdy; v.clr = c;
        v.e_vld = ev; v.e_res = eres[23:0]; v.e_sat = es; v.e_ovr = eo; v.e_busy = eb;
        tbl.push_back(v);
    endtask

    // Narrow instance: n-1 products of 16'hFFFF then 'last', checked one cycle after the last.
    task automatic s_vec(input string nm, input int n, input logic sat, input logic [15:0] last,
                         input logic [16:0] eres, input logic es);
        s_len = n[7:0];
        s_sat_en = sat;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_prod = (i == n - 1) ? last : 16'hFFFF;
            tick();
        end
        s_valid = 1'b0;
        chk(nm, 64'({s_res_valid, s_res_sat, s_res}), 64'({1'b1, es, eres}));
        tick();
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; prod_in = '0; prod_valid = 1'b0; vec_len = '0;
        sat_en = 1'b0; res_ready = 1'b1;
        s_prod = '0; s_valid = 1'b0; s_len = '0; s_sat_en = 1'b0;

        //    pv prod  len rdy clr  vld res   sat ovr busy
        // length 4, consecutive
        add(1, 100, 4, 1, 0,  0, 0,    0, 0, 1);
        add(1, 200, 4, 1, 0,  0, 0,    0, 0, 1);
        add(1, 300, 4, 1, 0,  0, 0,    0, 0, 1);
        add(1, 400, 4, 1, 0,  1, 1000, 0, 0, 0);
        add(0, 0,   4, 1, 0,  0, 0,    0, 0, 0);
        // length 3 with gaps, vec_len changed mid-vector
        add(1, 10,  3, 1, 0,  0, 0,    0, 0, 1);
        add(0, 0,   7, 1, 0,  0, 0,    0, 0, 1);
        add(0, 0,   7, 1, 0,  0, 0,    0, 0, 1);
        add(1, 20,  7, 1, 0,  0, 0,    0, 0, 1);
        add(0, 0,   7, 1, 0,  0, 0,    0, 0, 1);
        add(1, 30,  7, 1, 0,  1, 60,   0, 0, 0);
        add(0, 0,   7, 1, 0,  0, 0,    0, 0, 0);
        // vec_len 0 behaves as 1, then back-to-back
        add(1, 42,  0, 1, 0,  1, 42,   0, 0, 0);
        add(0, 0,   0, 1, 0,  0, 0,    0, 0, 0);
        add(1, 1,   0, 1, 0,  1, 1,    0, 0, 0);
        add(1, 2,   0, 1, 0,  1, 2,    0, 0, 0);
        add(1, 3,   0, 1, 0,  1, 3,    0, 0, 0);
        add(0, 0,   0, 1, 0,  0, 0,    0, 0, 0);
        // overrun: held result kept, sticky until clr
        add(1, 5,   1, 0, 0,  1, 5,    0, 0, 0);
        add(1, 6,   1, 0, 0,  1, 5,    0, 1, 0);
        add(0, 0,   1, 0, 0,  1, 5,    0, 1, 0);
        add(0, 0,   1, 1, 0,  0, 0,    0, 1, 0);
        add(0, 0,   1, 1, 0,  0, 0,    0, 1, 0);
        add(1, 9,   1, 1, 1,  0, 0,    0, 0, 0);
        // clr mid-vector, then a fresh vector
        add(1, 7,   4, 1, 0,  0, 0,    0, 0, 1);
        add(1, 7,   4, 1, 0,  0, 0,    0, 0, 1);
        add(1, 7,   4, 1, 1,  0, 0,    0, 0, 0);
        add(1, 1,   4, 1, 0,  0, 0,    0, 0, 1);
        add(1, 1,   4, 1, 0,  0, 0,    0, 0, 1);
        add(1, 1,   4, 1, 0,  0, 0,    0, 0, 1);
        add(1, 1,   4, 1, 0,  1, 4,    0, 0, 0);
        add(0, 0,   4, 1, 0,  0, 0,    0, 0, 0);

        repeat (2) tick();
        chk("reset_state", 64'({res_valid, overrun, busy, res_sat, res_out}), 64'd0);
        chk("reset_state_s", 64'({s_res_valid, s_overrun, s_busy, s_res_sat, s_res}), 64'd0);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            prod_valid = tbl[i].pv;
            prod_in    = tbl[i].prod;
            vec_len    = tbl[i].len;
            res_ready  = tbl[i].rdy;
            clr        = tbl[i].clr;
            tick();
            chk($sformatf("row%0d", i),
                64'({res_valid, overrun, busy, res_valid ? {res_sat, res_out} : 25'd0}),
                64'({tbl[i].e_vld, tbl[i].e_ovr, tbl[i].e_busy,
                     tbl[i].e_vld ? {tbl[i].e_sat, tbl[i].e_res} : 25'd0}));
        end
        clr = 1'b0;
        prod_valid = 1'b0;

        // Async reset mid-vector; held result (4) must clear without a clock edge.
        vec_len = 8'd4;
        prod_valid = 1'b1; prod_in = 16'd9;
        tick();
        tick();
        prod_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("async_rst_mid", 64'({res_valid, overrun, busy, res_sat, res_out}), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            prod_valid = 1'b1; prod_in = 16'd1;
            tick();
        end
        prod_valid = 1'b0;
        chk("after_rst_sum", 64'({res_valid, busy, res_out}), 64'({1'b1, 1'b0, 24'd4}));
        tick();

        // Largest vector the default widths allow: 255 * 65535 stays below 2^24.
        vec_len = 8'd255; sat_en = 1'b1;
        for (int i = 0; i < 255; i++) begin
            prod_valid = 1'b1; prod_in = 16'hFFFF;
            tick();
            if (i == 100) chk("busy_long", 64'(busy), 64'd1);
        end
        prod_valid = 1'b0;
        chk("max_vec", 64'({res_valid, res_sat, res_out}), 64'({1'b1, 1'b0, 24'd16711425}));
        tick();

        // Overflow on the 17-bit accumulator instance.
        s_vec("sat",        3, 1'b1, 16'hFFFF, 17'h1FFFF, 1'b1);
        s_vec("wrap",       3, 1'b0, 16'hFFFF, 17'h0FFFD, 1'b1);
        s_vec("sat_hold",   4, 1'b1, 16'h0005, 17'h1FFFF, 1'b1);
        s_vec("ovf_sticky", 4, 1'b0, 16'h0001, 17'h0FFFE, 1'b1);
        s_vec("no_ovf",     2, 1'b0, 16'hFFFF, 17'h1FFFE, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
